// File: rtl/shift_bit_feeder.sv
// Serializes parallel bytes accepted over valid/ready into a one-bit-per-strobe
// stream for the downstream shift register, with optional gap cycles per bit.
module shift_bit_feeder #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              msb_first,
    input  logic              flush,
    output logic              shift_en,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              msb_q, msb_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        gap_q, gap_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic is_last;
    logic cur_bit;

    assign is_last = (idx_q == IDX_LAST);
    assign cur_bit = msb_q ? hold_q[IDX_LAST - idx_q] : hold_q[idx_q];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        msb_d   = msb_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                // flush takes priority over a pending byte
                if (in_valid && !flush) begin
                    hold_d  = in_data;
                    msb_d   = msb_first;
                    idx_d   = '0;
                    last_d  = 1'b0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                idx_d  = idx_q + IDX_W'(1);
                gap_d  = '0;
                last_d = is_last;
                if (is_last) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (flush) begin
                    state_d = S_IDLE;
                end else if (GAP_CYCLES > 0) begin
                    state_d = S_GAP;
                end else if (is_last) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_GAP: begin
                gap_d = gap_q + 4'd1;
                if (flush) begin
                    state_d = S_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    state_d = last_q ? S_IDLE : S_SHIFT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            msb_q   <= 1'b0;
            idx_q   <= '0;
            gap_q   <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            msb_q   <= msb_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs decode registered state only.
    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign shift_en   = (state_q == S_SHIFT);
    assign frame_done = shift_en && is_last;
    assign data_out   = {{(DATA_W-1){1'b0}}, shift_en & cur_bit};
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_shift_bit_feeder.sv
// Self-checking bench for shift_bit_feeder: one instance without gaps (CNT_W=8)
// and one with GAP_CYCLES=2 and CNT_W=2, checked against an arithmetic timing model.
module tb_shift_bit_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       v0, v1;
    logic [7:0] in_data;
    logic       msb_first;
    logic       flush;

    logic       z_ready, z_se, z_fd, z_busy;
    logic [7:0] z_do, z_cnt;
    logic       g_ready, g_se, g_fd, g_busy;
    logic [7:0] g_do;
    logic [1:0] g_cnt;

    shift_bit_feeder #(.DATA_W(8), .GAP_CYCLES(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_data(in_data), .in_ready(z_ready),
        .msb_first(msb_first), .flush(flush), .shift_en(z_se), .data_out(z_do),
        .frame_done(z_fd), .busy(z_busy), .frame_cnt(z_cnt)
    );

    shift_bit_feeder #(.DATA_W(8), .GAP_CYCLES(2), .CNT_W(2)) dutg (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(in_data), .in_ready(g_ready),
        .msb_first(msb_first), .flush(flush), .shift_en(g_se), .data_out(g_do),
        .frame_done(g_fd), .busy(g_busy), .frame_cnt(g_cnt)
    );

    int checks = 0;
    int errors = 0;
    int exp_cnt [2];
    int sel;

    logic       m_ready, m_se, m_fd, m_busy;
    logic [7:0] m_do;
    int         m_cnt;

    always_comb begin
        if (sel == 1) begin
            m_ready = g_ready; m_se = g_se; m_fd = g_fd; m_busy = g_busy;
            m_do = g_do; m_cnt = int'(g_cnt);
        end else begin
            m_ready = z_ready; m_se = z_se; m_fd = z_fd; m_busy = z_busy;
            m_do = z_do; m_cnt = int'(z_cnt);
        end
    end

    typedef struct {
        int         s;
        logic [7:0] data;
        bit         msb;
        int         flush_k;
        bit         keep;
        int         exp_strobes;
        int         exp_done;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Expects DUT idle and caller before a rising edge; returns at the negedge
    // of the idle cycle that follows the frame.
    task automatic run_frame(input int s, input logic [7:0] d, input bit msb,
                             input int flush_k, input bit keep,
                             output int n_strobe, output int n_done);
        int p, ncyc, k;
        bit strobe;
        logic eb;
        logic [7:0] exp_do;
        sel = s;
        p = (s == 1) ? 3 : 1;
        in_data = d;
        msb_first = msb;
        if (s == 1) v1 = 1'b1; else v0 = 1'b1;
        @(posedge clk); #1;
        if (!keep) begin v0 = 1'b0; v1 = 1'b0; end
        ncyc = (flush_k < 0) ? 8 * p : flush_k * p + 1;
        n_strobe = 0;
        n_done = 0;
        for (int c = 1; c <= ncyc; c++) begin
            flush = (flush_k >= 0 && c == ncyc);
            if (!keep) begin
                in_data = 8'($urandom);
                msb_first = 1'($urandom);
            end
            strobe = ((c - 1) % p) == 0;
            k = (c - 1) / p;
            eb = msb ? d[7-k] : d[k];
            exp_do = strobe ? {7'd0, eb} : 8'd0;
            @(negedge clk);
            chk("shift_en", int'(m_se), int'(strobe));
            chk("data_out", int'(m_do), int'(exp_do));
            chk("frame_done", int'(m_fd), int'(strobe && k == 7));
            chk("busy", int'(m_busy), 1);
            chk("in_ready_busy", int'(m_ready), 0);
            if (m_se) n_strobe++;
            if (m_fd) n_done++;
            if (strobe && k == 7) exp_cnt[s]++;
            @(posedge clk); #1;
        end
        flush = 1'b0;
        @(negedge clk);
        chk("in_ready_after", int'(m_ready), 1);
        chk("busy_after", int'(m_busy), 0);
        chk("shift_en_after", int'(m_se), 0);
        chk("frame_cnt", m_cnt, exp_cnt[s] % ((s == 1) ? 4 : 256));
        $display("frame dut=%0d data=%h msb=%0d flush_k=%0d strobes=%0d done=%0d cnt=%0d",
                 s, d, msb, flush_k, n_strobe, n_done, m_cnt);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int ns, nd, fk;
        tbl[0] = '{0, 8'h1E, 1'b0, -1, 1'b0, 8, 1};
        tbl[1] = '{0, 8'h1E, 1'b1, -1, 1'b0, 8, 1};
        tbl[2] = '{1, 8'hFF, 1'b0, -1, 1'b0, 8, 1};
        tbl[3] = '{0, 8'h01, 1'b0, -1, 1'b1, 8, 1};
        tbl[4] = '{0, 8'h80, 1'b0, -1, 1'b0, 8, 1};
        tbl[5] = '{0, 8'hAA, 1'b0,  3, 1'b0, 4, 0};
        tbl[6] = '{0, 8'h5C, 1'b1,  7, 1'b0, 8, 1};
        tbl[7] = '{1, 8'h3C, 1'b0,  2, 1'b0, 3, 0};
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;

        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; flush = 1'b0;
        in_data = 8'h00; msb_first = 1'b0; sel = 0;
        #2;
        chk("rst_in_ready", int'(z_ready), 1);
        chk("rst_busy", int'(z_busy), 0);
        chk("rst_shift_en", int'(z_se), 0);
        chk("rst_data_out", int'(z_do), 0);
        chk("rst_frame_done", int'(z_fd), 0);
        chk("rst_frame_cnt", int'(z_cnt), 0);
        chk("rst_g_in_ready", int'(g_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].s, tbl[i].data, tbl[i].msb, tbl[i].flush_k, tbl[i].keep, ns, nd);
            chk("tbl_strobes", ns, tbl[i].exp_strobes);
            chk("tbl_done", nd, tbl[i].exp_done);
        end
        v0 = 1'b0; v1 = 1'b0;

        // flush in IDLE blocks the handshake
        sel = 0;
        v0 = 1'b1; flush = 1'b1; in_data = 8'hC3;
        @(posedge clk); #1;
        v0 = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", int'(z_busy), 0);
        chk("idle_flush_shift_en", int'(z_se), 0);
        $display("idle flush with in_valid busy=%0d", z_busy);

        // asynchronous reset between edges mid-frame
        in_data = 8'hF0; msb_first = 1'b0; v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_shift_en", int'(z_se), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_shift_en", int'(z_se), 0);
        chk("arst_busy", int'(z_busy), 0);
        chk("arst_in_ready", int'(z_ready), 1);
        chk("arst_frame_cnt", int'(z_cnt), 0);
        chk("arst_g_frame_cnt", int'(g_cnt), 0);
        #1 rst = 1'b0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        $display("async reset mid-frame shift_en=%0d busy=%0d", z_se, z_busy);
        run_frame(0, 8'h96, 1'b1, -1, 1'b0, ns, nd);
        chk("post_rst_strobes", ns, 8);

        // 2-bit frame counter wraps 1,2,3,0
        for (int i = 0; i < 4; i++) begin
            run_frame(1, 8'($urandom), 1'($urandom), -1, 1'b0, ns, nd);
        end
        chk("cnt_wrap", int'(g_cnt), 0);

        for (int i = 0; i < 20; i++) begin
            fk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_frame(int'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), fk, 1'b0, ns, nd);
            chk("rand_strobes", ns, (fk < 0) ? 8 : fk + 1);
            chk("rand_done", nd, (fk < 0 || fk == 7) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_bit_feeder.md
Name: shift_bit_feeder

Overview:
- Upstream stage of the 8-bit shift-register/tap-mux block.
- Accepts parallel bytes over a valid/ready handshake and serializes each byte into a one-bit-per-strobe stream.
- Drives the downstream block's shift_en and data_in (bit 0 carries the serial bit).
- Supports inter-bit gap insertion, selectable bit order, mid-frame flush, and a completed-frame counter.

Parameters:
- DATA_W, 8, bits per frame; must be >= 2.
- GAP_CYCLES, 0, idle cycles inserted after each bit strobe, including after the last bit; range 0..15.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream byte valid.
- in_data  input  DATA_W  upstream byte.
- in_ready  output  1  block can accept a byte.
- msb_first  input  1  bit order; sampled only at handshake.
- flush  input  1  synchronous abort of the current frame.
- shift_en  output  1  one-cycle strobe per serial bit.
- data_out  output  DATA_W  bit 0 = current serial bit; bits [DATA_W-1:1] are always 0.
- frame_done  output  1  one-cycle pulse on the last bit strobe of a frame.
- busy  output  1  frame in progress.
- frame_cnt  output  CNT_W  completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, applied immediately):
  - state=IDLE; hold register, bit counter, gap counter and frame_cnt cleared.
  - shift_en=0, data_out=0, frame_done=0, busy=0.
  - in_ready=1, since it is decoded from IDLE.
- FSM states:
  - IDLE: in_ready=1, busy=0. Handshake = in_valid && in_ready at a rising edge. On handshake: capture in_data and msb_first, clear bit_idx, go to SHIFT.
  - SHIFT: in_ready=0, busy=1, shift_en=1. data_out[0] = hold[bit_idx] for LSB-first, hold[DATA_W-1-bit_idx] for MSB-first. bit_idx increments each SHIFT cycle.
    - If bit_idx == DATA_W-1: frame_done=1 this cycle, frame_cnt increments at this edge. Next state is GAP if GAP_CYCLES>0, else IDLE.
    - Otherwise: next state is GAP if GAP_CYCLES>0, else stay in SHIFT.
  - GAP: shift_en=0, data_out=0, busy=1. Counts GAP_CYCLES cycles. Then goes to SHIFT, or to IDLE if the frame's last bit has already been sent.
- Outputs shift_en, data_out and frame_done are registered-state decodes: no combinational path from in_valid or in_data.
- Latency, handshake at edge N:
  - First shift_en in cycle N+1.
  - Bit k strobes in cycle N+1+k*(GAP_CYCLES+1).
  - in_ready returns high in cycle N+1+DATA_W*(GAP_CYCLES+1).
  - GAP_CYCLES=0: 8 strobes in N+1..N+8, frame_done in N+8, in_ready high in N+9 (9 cycles/byte max throughput).
- in_data and msb_first changes while busy are ignored; the hold register is frozen.
- flush:
  - Sampled in SHIFT or GAP: next state IDLE, no further strobes, no frame_done, frame_cnt unchanged.
  - The strobe in the flush cycle itself still occurs.
  - Sampled in IDLE with in_valid=1: flush wins and no byte is accepted.
- flush coinciding with the last-bit SHIFT cycle: frame_done still pulses and frame_cnt still increments, since the frame is complete.
- frame_cnt at all-ones plus one completed frame wraps to 0.
- in_valid held high continuously: one byte accepted per frame; each handshake consumes exactly one byte.
- Reset asserted mid-frame: immediate return to the reset values above; the partial frame is discarded.

Test Plan:
- Reset, then in_data=0x1E, msb_first=0, GAP=0 -> shift_en high 8 consecutive cycles; data_out[0] = 0,1,1,1,1,0,0,0; frame_done on the 8th strobe; frame_cnt=1; in_ready high the following cycle.
- Same byte 0x1E, msb_first=1 -> bits 0,0,0,1,1,1,1,0.
- GAP_CYCLES=2, in_data=0xFF -> strobes every 3rd cycle (cycles N+1, N+4, ..., N+22); in_ready high at N+25; data_out=0 during gaps.
- in_valid held high with bytes 0x01, 0x80 presented back-to-back, LSB-first -> frames separated by exactly one IDLE cycle; bits 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1; frame_cnt=2.
- flush asserted on the 4th strobe of 0xAA -> exactly 4 strobes, no frame_done, frame_cnt unchanged, in_ready high next cycle.
- Async rst pulse between clock edges mid-frame -> shift_en and busy drop without waiting for a clock edge; frame_cnt=0; next byte serializes normally.
- CNT_W=2, 4 frames -> frame_cnt sequence 1, 2, 3, 0.
